// File: rtl/hazard_ctrl_pkg.sv
// Shared types, widths and the load-use compare for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_W      = 5;
  localparam int MD_CNT_W   = 4;
  localparam int WAIT_CNT_W = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  // A load in E whose destination feeds D cannot be forwarded in time.
  // x0 is never a real dependency.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2
  );
    return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_counter.sv
// Loadable down-counter with a freeze enable and a zero flag; tracks the
// remaining mul/div occupancy cycles.
module stall_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count parks at zero and holds when frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (load_i)             cnt_d = load_val_i;
      else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken
// branch flushes, mul/div occupancy of E, data-memory wait states and a
// sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MdBusy,
  output logic             MemErr
);

  // The arrival cycle is spent in IDLE and the release cycle at count zero,
  // so the counter only covers the cycles in between.
  localparam logic [MD_CNT_W-1:0]   MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);
  localparam logic [WAIT_CNT_W-1:0] TMO     = WAIT_CNT_W'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic                  mem_wait;
  logic                  md_enter, md_stall, md_zero, md_cnt_en;
  logic                  lu_hit, branch, stall_e;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;

  assign mem_wait = MemReqM & ~MemAckM;

  // Next state for mul/div occupancy; a memory wait freezes everything.
  always_comb begin
    state_d  = state_q;
    md_enter = 1'b0;
    md_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mem_wait && MulDivE) begin
          md_enter = 1'b1;
          md_stall = 1'b1;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (!mem_wait) begin
          if (!md_zero) md_stall = 1'b1;
          else          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any occupancy in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign md_cnt_en = ~mem_wait & (md_enter | (state_q == MD_BUSY));

  stall_counter #(.W(MD_CNT_W)) u_md_cnt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (md_cnt_en),
    .load_i     (md_enter),
    .load_val_i (MD_LOAD),
    .zero_o     (md_zero)
  );

  assign stall_e = mem_wait | md_stall;
  assign lu_hit  = (state_q == IDLE) & ~mem_wait & load_use_hit(MemReadE, RdE, Rs1D, Rs2D);
  // A branch held in a stalled E keeps PCSrcE high, so it fires on release.
  assign branch  = PCSrcE & ~stall_e;

  // Stall/flush outputs, all forced low while reset is asserted.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      StallF = stall_e | (lu_hit & ~branch);
      StallD = stall_e | (lu_hit & ~branch);
      StallE = stall_e;
      StallM = mem_wait;
      FlushD = branch;
      FlushE = branch | lu_hit;
      FlushM = md_stall;
      FlushW = mem_wait;
    end
  end

  // Consecutive wait-cycle count, saturating; the flag latches once the
  // count reaches the timeout.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait) wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    err_d = err_q | (wait_cnt_d >= TMO);
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign MdBusy = ~rst & (state_q == MD_BUSY);
  assign MemErr = ~rst & err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: each stimulus cycle queues its expected output vector;
// a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       MemReadE, PCSrcE, MulDivE, MemReqM, MemAckM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic       MdBusy, MemErr;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  string      name_q[$];
  logic [9:0] obs;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MdBusy(MdBusy), .MemErr(MemErr)
  );

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW, MdBusy,MemErr}
  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdBusy, MemErr};

  task automatic step(input string nm, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic pc, input logic md,
                      input logic mq, input logic ma, input logic [9:0] e);
    @(posedge clk);
    #1;
    rst = r; Rs1D = rs1; Rs2D = rs2; RdE = rd;
    MemReadE = mr; PCSrcE = pc; MulDivE = md; MemReqM = mq; MemAckM = ma;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation in its own cycle.
  initial begin
    logic [9:0] e;
    string      n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL %s got %b want %b", n, obs, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0;
    MemReadE = 0; PCSrcE = 0; MulDivE = 0; MemReqM = 0; MemAckM = 0;

    //     name          rst rs1 rs2 rd  mr pc md mq ma  expected
    step("rst_idle",     1, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    step("rst_gated",    1, 5, 0, 5,   1, 1, 1, 1, 0, 10'b0000_0000_00);
    step("post_rst",     0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    // load-use
    step("lu_rs1",       0, 5, 0, 5,   1, 0, 0, 0, 0, 10'b1100_0100_00);
    step("lu_bubble1",   0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    step("lu_x0",        0, 0, 0, 0,   1, 0, 0, 0, 0, 10'b0000_0000_00);
    step("lu_rs2",       0, 3, 7, 7,   1, 0, 0, 0, 0, 10'b1100_0100_00);
    step("lu_nomatch",   0, 8, 9, 7,   1, 0, 0, 0, 0, 10'b0000_0000_00);
    step("lu_noload",    0, 5, 5, 5,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    // mul/div occupancy, MD_LATENCY=4
    step("md_c0",        0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_00);
    step("md_c1",        0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("md_c2",        0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("md_c3",        0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b0000_0000_10);
    step("md_after",     0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    // mem wait inside mul/div: E held 6 cycles
    step("mdw_c0",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_00);
    step("mdw_wait1",    0, 0, 0, 0,   0, 0, 1, 1, 0, 10'b1111_0001_10);
    step("mdw_wait2",    0, 0, 0, 0,   0, 0, 1, 1, 0, 10'b1111_0001_10);
    step("mdw_c3",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("mdw_c4",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("mdw_c5",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b0000_0000_10);
    step("mdw_after",    0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    step("mem_acked",    0, 0, 0, 0,   0, 0, 0, 1, 1, 10'b0000_0000_00);
    // branch priority and deferral
    step("br_vs_lu",     0, 5, 0, 5,   1, 1, 0, 0, 0, 10'b0000_1100_00);
    step("br_plain",     0, 0, 0, 0,   0, 1, 0, 0, 0, 10'b0000_1100_00);
    step("br_deferred",  0, 0, 0, 0,   0, 1, 0, 1, 0, 10'b1111_0001_00);
    step("br_release",   0, 0, 0, 0,   0, 1, 0, 0, 0, 10'b0000_1100_00);
    // mem wait beats mul/div entry (and suppresses load-use)
    step("mdent_wait",   0, 5, 0, 5,   1, 0, 1, 1, 0, 10'b1111_0001_00);
    step("mdent_retry",  0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_00);
    step("mdent_c1",     0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("mdent_c2",     0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("mdent_c3",     0, 5, 0, 5,   1, 0, 1, 0, 0, 10'b0000_0000_10);
    step("mdent_after",  0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    // timeout, MEM_TIMEOUT=3
    step("tmo_w1",       0, 0, 0, 0,   0, 0, 0, 1, 0, 10'b1111_0001_00);
    step("tmo_w2",       0, 0, 0, 0,   0, 0, 0, 1, 0, 10'b1111_0001_00);
    step("tmo_w3",       0, 0, 0, 0,   0, 0, 0, 1, 0, 10'b1111_0001_00);
    step("tmo_w4",       0, 0, 0, 0,   0, 0, 0, 1, 0, 10'b1111_0001_01);
    step("tmo_w5",       0, 0, 0, 0,   0, 0, 0, 1, 0, 10'b1111_0001_01);
    step("tmo_ack",      0, 0, 0, 0,   0, 0, 0, 1, 1, 10'b0000_0000_01);
    step("tmo_sticky",   0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_01);
    // reset mid-occupancy (md_cnt=2)
    step("rmd_enter",    0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_01);
    step("rmd_reset",    1, 0, 0, 0,   0, 0, 1, 0, 0, 10'b0000_0000_00);
    step("rmd_idle",     0, 0, 0, 0,   0, 0, 0, 0, 0, 10'b0000_0000_00);
    step("rmd_reenter",  0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_00);
    step("rmd_c1",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("rmd_c2",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b1110_0010_10);
    step("rmd_c3",       0, 0, 0, 0,   0, 0, 1, 0, 0, 10'b0000_0000_10);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside `forwarding_unit` and covers the hazards that forwarding cannot resolve: load-use hazards, taken branches and jumps, multi-cycle mul/div occupancy of Execute, and data-memory wait states. It also flags a sticky error when a memory access times out.

## Interface

Parameters:
- `MD_LATENCY`, default 4: cycles a mul/div instruction occupies E, counting its arrival cycle. Legal range 2..16.
- `MEM_TIMEOUT`, default 255: consecutive unacked memory-wait cycles before the error flag sets. Legal range 1..1023.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `Rs1D`, `Rs2D` in 5: source registers of the instruction in D.
- `RdE` in 5: destination register of the instruction in E.
- `MemReadE` in 1: the instruction in E is a load.
- `PCSrcE` in 1: a branch or jump resolved taken in E.
- `MulDivE` in 1: the instruction in E is a mul/div.
- `MemReqM` in 1: the instruction in M accesses data memory.
- `MemAckM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushM`, `FlushW` out 1: load a bubble into the corresponding pipeline register.
- `MdBusy` out 1: mul/div occupancy is in progress.
- `MemErr` out 1: sticky memory-timeout flag, cleared only by `rst`.

## Operation

Mem wait is combinational and has the highest priority.
- Condition: `MemReqM & ~MemAckM`.
- Response: `StallF=StallD=StallE=StallM=1` and `FlushW=1`.
- While it holds, `FlushD`, `FlushE` and `FlushM` are 0, and the mul/div counter is frozen.

State machine: states `IDLE` and `MD_BUSY`, with a counter `md_cnt`.
- In `IDLE`, with no mem wait and `MulDivE=1`:
  - Assert `StallF`, `StallD`, `StallE` and `FlushM`.
  - Load `md_cnt = MD_LATENCY-2` and go to `MD_BUSY`.
- In `MD_BUSY` with `md_cnt != 0`, and no mem wait:
  - Assert the same stalls plus `FlushM`.
  - Decrement `md_cnt`.
- In `MD_BUSY` with `md_cnt == 0`, and no mem wait:
  - No mul/div stall; the instruction advances.
  - Go to `IDLE`.
- `MdBusy = (state == MD_BUSY)`.

Load-use hazard, evaluated only in `IDLE` with no mem wait:
- Condition: `MemReadE & RdE != 0 & (RdE == Rs1D | RdE == Rs2D)`.
- Response: `StallF=StallD=1`, `FlushE=1`.

Taken branch, only when E is not stalled:
- Condition: `PCSrcE=1`.
- Response: `FlushD=FlushE=1`.
- If E is stalled, the flush is deferred. `PCSrcE` stays asserted while E is held, so it fires on the release cycle.

Simultaneous events:
- Load-use and `PCSrcE` in the same cycle: the branch wins. `FlushD=FlushE=1` and `StallF=StallD=0`.
- Mem wait and mul/div entry in the same cycle: mem wait wins. State stays `IDLE` and entry is retried on the next cycle.

Memory timeout:
- `wait_cnt` (10 bits) increments on each mem-wait cycle, saturates, and clears on any cycle without mem wait.
- When `wait_cnt` reaches `MEM_TIMEOUT`, `MemErr` is set and stays set.
- Stalls continue after `MemErr` sets; the core is not aborted.

## Timing

- All stall/flush outputs are combinational from the inputs and the current state, within the same cycle.
- `MdBusy` and `MemErr` are registered.
- Reset:
  - Under `rst=1`, all outputs are 0, including the combinational ones (gated).
  - On the next edge: `state=IDLE`, `md_cnt=0`, `wait_cnt=0`, `MemErr=0`.
- Mul/div occupancy: E holds the instruction for exactly `MD_LATENCY` cycles with no mem wait, and `MD_LATENCY + N` cycles if N mem-wait cycles overlap.
- Load-use costs one bubble: `FlushE` for one cycle, `StallF`/`StallD` for one cycle.
- Reset asserted mid-occupancy aborts it. The state returns to `IDLE` on the next edge regardless of `md_cnt`.
- `Rs1D`/`Rs2D` equal to x0 never cause a stall.

## Structure

- `hazard_ctrl_pkg` holds:
  - the state enum (`IDLE`, `MD_BUSY`);
  - the widths `REG_W=5`, `MD_CNT_W=4`, `WAIT_CNT_W=10`.
- One sub-module, `stall_counter`: a loadable down-counter with an enable (freeze) and a zero flag. It implements `md_cnt`.
- The timeout counter is inline.

## Test plan

- **Load-use:** `MemReadE=1`, `RdE=5`, `Rs1D=5` → `StallF=StallD=FlushE=1` for one cycle. Repeat with `RdE=0` → no stall.
- **Mul/div occupancy:** `MulDivE=1` at cycle 0 with `MD_LATENCY=4` → stalls and `FlushM` high in cycles 0–2, low in cycle 3. `MdBusy` high in cycles 1–3.
- **Mem wait inside mul/div:** `MemReqM=1`, `MemAckM=0` during `MD_BUSY` for 2 cycles → `StallM` and `FlushW` high, `md_cnt` frozen, E held for 6 cycles in total.
- **Branch priority:** `PCSrcE=1` together with a load-use condition → `FlushD=FlushE=1`, `StallF=0`.
- **Timeout:** `MEM_TIMEOUT=3`, `MemReqM=1`, `MemAckM=0` held for 5 cycles → `MemErr` rises after the 3rd wait cycle and stays 1 after the ack, until `rst`.
- **Reset mid-operation:** `rst=1` during `MD_BUSY` with `md_cnt=2` → all outputs 0 that cycle, `state=IDLE` after the edge, `MdBusy=0`.
